// File: rtl/cnn_mac_pkg.sv
// Shared widths, helpers and the stage-1 record for the shared-DSP MAC scheduler.
package cnn_mac_pkg;

    localparam int MAC_NREQ  = 4;
    localparam int MAC_A_W   = 10;
    localparam int MAC_B_W   = 14;
    localparam int MAC_P_W   = 25;
    localparam int MAC_ACC_W = 32;

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Stage-1 id field is sized for the largest supported requester count (8).
    localparam int MAC_ID_W = id_width(8);

    function automatic logic signed [MAC_ACC_W-1:0] sext_acc(input logic signed [MAC_P_W-1:0] p);
        return MAC_ACC_W'(p);
    endfunction

    typedef struct packed {
        logic                       valid;
        logic [MAC_ID_W-1:0]        id;
        logic                       last;
        logic signed [MAC_A_W-1:0]  a;
        logic signed [MAC_B_W-1:0]  b;
    } s1_t;

endpackage

// File: rtl/cnn_mac_rr_arb.sv
// Round-robin arbiter: one-hot grant starting after the last advanced grant.
module cnn_mac_rr_arb
    import cnn_mac_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = id_width(NREQ)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_advance,
    output logic [NREQ-1:0] o_grant,
    output logic [ID_W-1:0] o_grant_id
);

    logic [ID_W-1:0]   r_ptr;
    logic [2*NREQ-1:0] w_req_dbl;
    logic [NREQ-1:0]   w_req_rot;
    logic [ID_W-1:0]   w_off;
    logic              w_found;
    logic [ID_W:0]     w_id_raw;
    logic [ID_W:0]     w_id_wrap;

    // Rotate so that the priority position r_ptr lands on bit 0.
    assign w_req_dbl = {i_req, i_req};
    assign w_req_rot = NREQ'(w_req_dbl >> r_ptr);
    assign w_found   = |w_req_rot;

    always_comb begin
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_off = ID_W'(k);
            end
        end
    end

    assign w_id_raw   = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_id_wrap  = (w_id_raw >= (ID_W+1)'(NREQ)) ? (w_id_raw - (ID_W+1)'(NREQ)) : w_id_raw;
    assign o_grant_id = ID_W'(w_id_wrap);
    assign o_grant    = w_found ? (NREQ'(1) << o_grant_id) : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= (o_grant_id == ID_W'(NREQ - 1)) ? '0 : (o_grant_id + ID_W'(1));
        end
    end

endmodule

// File: rtl/cnn_mac_rr_sched.sv
// Shares one signed multiplier among NREQ lanes, keeps a running sum per lane
// and emits each finished dot product with its lane id.
module cnn_mac_rr_sched
    import cnn_mac_pkg::*;
#(
    parameter int NREQ  = MAC_NREQ,
    parameter int A_W   = MAC_A_W,
    parameter int B_W   = MAC_B_W,
    parameter int P_W   = MAC_P_W,
    parameter int ACC_W = MAC_ACC_W
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*A_W-1:0]         req_a,
    input  logic [NREQ*B_W-1:0]         req_b,
    input  logic [NREQ-1:0]             req_last,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic signed [ACC_W-1:0]     res_data,
    output logic [id_width(NREQ)-1:0]   res_id,
    output logic                        busy
);

    localparam int ID_W = id_width(NREQ);

    s1_t                     r_s1;
    logic signed [ACC_W-1:0] r_acc [NREQ];
    logic                    r_res_valid;
    logic signed [ACC_W-1:0] r_res_data;
    logic [ID_W-1:0]         r_res_id;

    logic [NREQ-1:0]         w_grant;
    logic [ID_W-1:0]         w_grant_id;
    logic                    w_stall;
    logic                    w_advance;
    logic                    w_acc_en;
    logic                    w_res_load;
    logic [A_W-1:0]          w_sel_a;
    logic [B_W-1:0]          w_sel_b;
    logic                    w_sel_last;
    logic signed [P_W-1:0]   w_a_ext;
    logic signed [P_W-1:0]   w_b_ext;
    logic signed [P_W-1:0]   w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_acc_sel;
    logic signed [ACC_W-1:0] w_sum;

    // Only a finishing beat that cannot unload into a full output register stalls.
    assign w_stall   = r_s1.valid & r_s1.last & r_res_valid & ~res_ready;
    assign w_advance = ~w_stall;

    cnn_mac_rr_arb #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .i_clk      (ap_clk),
        .i_rst_n    (ap_rst_n),
        .i_req      (req_valid),
        .i_advance  (w_advance),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id)
    );

    assign req_ready = w_grant & {NREQ{w_advance & ap_rst_n}};

    always_comb begin
        w_sel_a    = '0;
        w_sel_b    = '0;
        w_sel_last = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant[k]) begin
                w_sel_a    = req_a[k*A_W +: A_W];
                w_sel_b    = req_b[k*B_W +: B_W];
                w_sel_last = req_last[k];
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_s1 <= '0;
        end else if (w_advance) begin
            r_s1.valid <= |w_grant;
            r_s1.id    <= MAC_ID_W'(w_grant_id);
            r_s1.last  <= w_sel_last;
            r_s1.a     <= w_sel_a;
            r_s1.b     <= w_sel_b;
        end
    end

    assign w_a_ext    = P_W'($signed(r_s1.a));
    assign w_b_ext    = P_W'($signed(r_s1.b));
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = ACC_W'(w_prod);

    always_comb begin
        w_acc_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (r_s1.id == MAC_ID_W'(k)) begin
                w_acc_sel = r_acc[k];
            end
        end
    end

    // Single accumulate stage: a same-lane beat next cycle reads the value written here.
    assign w_sum      = w_acc_sel + w_prod_ext;
    assign w_acc_en   = r_s1.valid & w_advance;
    assign w_res_load = w_acc_en & r_s1.last;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int k = 0; k < NREQ; k++) begin
                r_acc[k] <= '0;
            end
        end else if (w_acc_en) begin
            for (int k = 0; k < NREQ; k++) begin
                if (r_s1.id == MAC_ID_W'(k)) begin
                    r_acc[k] <= r_s1.last ? '0 : w_sum;
                end
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= '0;
        end else if (w_res_load) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_sum;
            r_res_id    <= ID_W'(r_s1.id);
        end else if (res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
    assign busy      = r_s1.valid | r_res_valid;

endmodule

// File: tb/tb_cnn_mac_rr_sched.sv
// Directed bench for cnn_mac_rr_sched: vector table plus hand-written multi-cycle sequences.
module tb_cnn_mac_rr_sched;

    localparam int NREQ  = 4;
    localparam int A_W   = 10;
    localparam int B_W   = 14;
    localparam int P_W   = 25;
    localparam int ACC_W = 32;

    logic                    ap_clk = 1'b0;
    logic                    ap_rst_n = 1'b0;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*A_W-1:0]     req_a;
    logic [NREQ*B_W-1:0]     req_b;
    logic [NREQ-1:0]         req_last;
    logic                    res_valid;
    logic                    res_ready;
    logic signed [ACC_W-1:0] res_data;
    logic [1:0]              res_id;
    logic                    busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int     id;
        int     a;
        int     b;
        longint exp;
    } vec_t;

    vec_t tbl [6];

    cnn_mac_rr_sched #(
        .NREQ  (NREQ),
        .A_W   (A_W),
        .B_W   (B_W),
        .P_W   (P_W),
        .ACC_W (ACC_W)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_last  (req_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, required finish before 300000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic set_req(input int r, input int a, input int b, input bit last);
        req_valid[r]            = 1'b1;
        req_a[r*A_W +: A_W]     = A_W'(a);
        req_b[r*B_W +: B_W]     = B_W'(b);
        req_last[r]             = last;
    endtask

    task automatic clr_req(input int r);
        req_valid[r] = 1'b0;
        req_last[r]  = 1'b0;
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Entered at posedge+1; returns at posedge+1 of the cycle after the accepting edge.
    task automatic send(input int r, input int a, input int b, input bit last, output int waits);
        set_req(r, a, b, last);
        waits = 0;
        #1;
        while (!req_ready[r] && waits < 50) begin
            @(posedge ap_clk);
            #2;
            waits++;
        end
        if (!req_ready[r]) chk("accept_timeout", 0, 1);
        tick();
        clr_req(r);
    endtask

    task automatic chk_res(input string name, input longint data, input longint id);
        chk({name, "_valid"}, longint'(res_valid), 1);
        chk({name, "_data"}, longint'(res_data), data);
        chk({name, "_id"}, longint'(res_id), id);
        $display("result %s: id=%0d data=%0d", name, res_id, res_data);
    endtask

    initial begin
        int w;
        int cnt [2];
        int got [4];
        int results;

        tbl[0] = '{3, -512, -8192, 4194304};
        tbl[1] = '{3,  511,  8191, 4185601};
        tbl[2] = '{0,    3,     5, 15};
        tbl[3] = '{1,   -7,     9, -63};
        tbl[4] = '{2, -512,  8191, -4193792};
        tbl[5] = '{1,    0, -8192, 0};

        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_last  = '0;
        res_ready = 1'b1;

        // Reset state, with every requester already asking.
        #1;
        chk("rst_req_ready", longint'(req_ready), 0);
        chk("rst_res_valid", longint'(res_valid), 0);
        chk("rst_res_data", longint'(res_data), 0);
        chk("rst_res_id", longint'(res_id), 0);
        chk("rst_busy", longint'(busy), 0);

        // Fairness: grants rotate 0,1,2,3,... from reset.
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #2;
        chk("fair_0", longint'(req_ready), 1);
        $display("fair cycle 0 ready=%b", req_ready);
        for (int k = 1; k < 12; k++) begin
            @(posedge ap_clk);
            #2;
            chk($sformatf("fair_%0d", k), longint'(req_ready), longint'(1 << (k % 4)));
            $display("fair cycle %0d ready=%b", k, req_ready);
        end
        tick();
        req_valid = '0;
        ap_rst_n = 1'b0;
        #3;
        ap_rst_n = 1'b1;
        tick();

        // Single dot product, back-to-back beats from requester 0.
        send(0, 3, 5, 1'b0, w);
        chk("t1_beat0_wait", w, 0);
        send(0, -2, 7, 1'b0, w);
        chk("t1_beat1_wait", w, 0);
        send(0, 4, -1, 1'b1, w);
        chk("t1_beat2_wait", w, 0);
        chk("t1_early_valid", longint'(res_valid), 0);
        tick();
        chk_res("t1", -3, 0);
        tick();
        chk("t1_drained", longint'(res_valid), 0);

        // Table of single-beat dot products, including operand extremes.
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].id, tbl[i].a, tbl[i].b, 1'b1, w);
            chk($sformatf("vec%0d_early_valid", i), longint'(res_valid), 0);
            tick();
            chk_res($sformatf("vec%0d", i), tbl[i].exp, tbl[i].id);
            tick();
        end

        // Backpressure: second result stalls in stage 1 until the first is taken.
        res_ready = 1'b0;
        send(1, 2, 3, 1'b1, w);
        send(2, 4, 5, 1'b1, w);
        chk("bp_second_wait", w, 0);
        set_req(0, 1, 1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk_res($sformatf("bp_hold%0d", k), 6, 1);
            chk($sformatf("bp_busy%0d", k), longint'(busy), 1);
            #1;
            chk($sformatf("bp_noready%0d", k), longint'(req_ready), 0);
            @(posedge ap_clk);
            #1;
        end
        res_ready = 1'b1;
        #1;
        chk("bp_release_ready", longint'(req_ready), 1);
        chk_res("bp_first", 6, 1);
        tick();
        clr_req(0);
        chk_res("bp_second", 20, 2);
        tick();
        chk_res("bp_third", 1, 0);
        tick();
        chk("bp_drained", longint'(res_valid), 0);

        // Reset in the middle of a dot product discards the partial sum.
        send(2, 10, 10, 1'b0, w);
        chk("mr_busy_before", longint'(busy), 1);
        tick();
        set_req(2, 1, 1, 1'b1);
        #1;
        ap_rst_n = 1'b0;
        #1;
        chk("mr_req_ready", longint'(req_ready), 0);
        chk("mr_res_valid", longint'(res_valid), 0);
        chk("mr_res_data", longint'(res_data), 0);
        chk("mr_res_id", longint'(res_id), 0);
        chk("mr_busy", longint'(busy), 0);
        #1;
        ap_rst_n = 1'b1;
        #1;
        chk("mr_grant_after", longint'(req_ready), 4);
        tick();
        clr_req(2);
        tick();
        chk_res("mr", 1, 2);
        tick();

        // Interleaved long accumulations on requesters 0 and 1.
        cnt[0] = 0;
        cnt[1] = 0;
        for (int i = 0; i < 4; i++) got[i] = 0;
        results = 0;
        for (int cyc = 0; cyc < 600 && results < 2; cyc++) begin
            if (res_valid) begin
                chk("il_data", longint'(res_data), 419430400);
                chk("il_id_range", longint'(res_id < 2), 1);
                chk("il_id_fresh", got[res_id], 0);
                $display("result il: id=%0d data=%0d", res_id, res_data);
                got[res_id] = 1;
                results++;
            end
            for (int i = 0; i < 2; i++) begin
                if (cnt[i] < 100) set_req(i, -512, -8192, 1'b0);
                else if (cnt[i] == 100) set_req(i, 0, 0, 1'b1);
                else clr_req(i);
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                if (req_ready[i]) cnt[i]++;
            end
            tick();
        end
        clr_req(0);
        clr_req(1);
        chk("il_results", results, 2);
        chk("il_got0", got[0], 1);
        chk("il_got1", got[1], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
